uart_xcvr: RTL and testbench

- Parametrised full-duplex UART transceiver. Successor to the fixed 8N1 tx/rx pair.
- Adds:
  - configurable data width
  - runtime baud divisor with shared oversampling tick
  - runtime parity (none/even/odd) and 1/2 stop bits
  - majority-vote RX sampling with glitch rejection
  - valid/ready handshakes on both byte sides
  - parity, framing and overrun error reporting
- Sits between the debug/packet logic and the board UART pins.

---
 rtl/uart_xcvr.sv | 246 ++++++++++++++++++++++++
 tb/tb_uart_xcvr.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_xcvr.sv
// Full-duplex UART transceiver: runtime baud divisor, optional parity, 1/2 stop bits,
// 2-of-3 majority RX sampling, valid/ready byte handshakes and error reporting.
module uart_xcvr #(
    parameter int DATA_BITS   = 8,
    parameter int DIV_W       = 16,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DIV_W-1:0]     baud_div_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    input  logic                 two_stop_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 uart_txd_o,
    input  logic                 uart_rxd_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 rx_parity_err_o,
    output logic                 rx_frame_err_o,
    output logic                 rx_overrun_o
);

    localparam int CW = $clog2(OVERSAMPLE + 1);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] C_LAST       = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] C_START_LAST = CW'(OVERSAMPLE);
    localparam logic [CW-1:0] C_S0         = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_S1         = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] C_S2         = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] B_LAST       = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;

    assign w_tick = (r_div_cnt >= baud_div_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     r_div_cnt <= '0;
        else if (w_tick) r_div_cnt <= '0;
        else             r_div_cnt <= r_div_cnt + 1'b1;
    end

    // ---------------- transmitter ----------------
    state_e                r_tx_state;
    logic [CW-1:0]         r_tx_cnt;
    logic [BW-1:0]         r_tx_bit;
    logic [DATA_BITS-1:0]  r_tx_shift;
    logic                  r_tx_par;
    logic                  r_tx_pen;
    logic                  r_tx_two;
    logic                  r_tx_stop2;
    logic                  r_txd;
    logic                  r_tx_ready;
    logic                  w_tx_end;

    // The start bit runs a partial tick up to the first tick (a tick landing on the
    // accept cycle counts as that one) followed by OVERSAMPLE full ticks.
    assign w_tx_end = w_tick &&
                      (r_tx_cnt == ((r_tx_state == S_START) ? C_START_LAST : C_LAST));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_pen   <= 1'b0;
            r_tx_two   <= 1'b0;
            r_tx_stop2 <= 1'b0;
            r_txd      <= 1'b1;
            r_tx_ready <= 1'b0;
        end else begin
            if (w_tick && r_tx_state != S_IDLE)
                r_tx_cnt <= w_tx_end ? '0 : r_tx_cnt + 1'b1;
            case (r_tx_state)
                S_IDLE: begin
                    r_txd      <= 1'b1;
                    r_tx_ready <= 1'b1;
                    if (tx_valid_i && r_tx_ready) begin
                        r_tx_shift <= tx_data_i;
                        r_tx_par   <= (^tx_data_i) ^ parity_odd_i;
                        r_tx_pen   <= parity_en_i;
                        r_tx_two   <= two_stop_i;
                        r_tx_cnt   <= w_tick ? CW'(1) : '0;
                        r_txd      <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_tx_state <= S_START;
                    end
                end
                S_START: if (w_tx_end) begin
                    r_txd      <= r_tx_shift[0];
                    r_tx_shift <= r_tx_shift >> 1;
                    r_tx_bit   <= '0;
                    r_tx_state <= S_DATA;
                end
                S_DATA: if (w_tx_end) begin
                    if (r_tx_bit == B_LAST) begin
                        r_txd      <= r_tx_pen ? r_tx_par : 1'b1;
                        r_tx_stop2 <= 1'b0;
                        r_tx_state <= r_tx_pen ? S_PARITY : S_STOP;
                    end else begin
                        r_txd      <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= r_tx_bit + 1'b1;
                    end
                end
                S_PARITY: if (w_tx_end) begin
                    r_txd      <= 1'b1;
                    r_tx_stop2 <= 1'b0;
                    r_tx_state <= S_STOP;
                end
                S_STOP: if (w_tx_end) begin
                    if (r_tx_two && !r_tx_stop2) begin
                        r_tx_stop2 <= 1'b1;
                    end else begin
                        r_tx_ready <= 1'b1;
                        r_tx_state <= S_IDLE;
                    end
                end
                default: r_tx_state <= S_IDLE;
            endcase
        end
    end

    assign tx_ready_o = r_tx_ready;
    assign uart_txd_o = r_txd;

    // ---------------- receiver ----------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxd;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_sync <= '1;
        else         r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rxd_i};
    end

    assign w_rxd = r_sync[SYNC_STAGES-1];

    state_e                r_rx_state;
    logic [CW-1:0]         r_rx_cnt;
    logic [BW-1:0]         r_rx_bit;
    logic [DATA_BITS-1:0]  r_rx_shift;
    logic                  r_rx_pen;
    logic                  r_rx_odd;
    logic                  r_rx_armed;
    logic                  r_rx_v0;
    logic                  r_rx_v1;
    logic                  r_rx_perr;
    logic [DATA_BITS-1:0]  r_rx_data;
    logic                  r_rx_valid;
    logic                  r_rx_perr_o;
    logic                  r_rx_ferr_o;
    logic                  r_rx_ovr;
    logic                  w_rx_vote;
    logic                  w_rx_decide;
    logic                  w_rx_bit_end;

    assign w_rx_vote    = (r_rx_v0 & r_rx_v1) | (r_rx_v0 & w_rxd) | (r_rx_v1 & w_rxd);
    assign w_rx_decide  = w_tick && (r_rx_cnt == C_S2) && (r_rx_state != S_IDLE);
    assign w_rx_bit_end = w_tick && (r_rx_cnt == C_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_state  <= S_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_pen    <= 1'b0;
            r_rx_odd    <= 1'b0;
            r_rx_armed  <= 1'b0;
            r_rx_v0     <= 1'b1;
            r_rx_v1     <= 1'b1;
            r_rx_perr   <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_perr_o <= 1'b0;
            r_rx_ferr_o <= 1'b0;
            r_rx_ovr    <= 1'b0;
        end else begin
            r_rx_ovr <= 1'b0;
            if (r_rx_valid && rx_ready_i) r_rx_valid <= 1'b0;
            if (w_tick && w_rxd)          r_rx_armed <= 1'b1;
            if (w_tick && r_rx_state != S_IDLE) begin
                r_rx_cnt <= w_rx_bit_end ? '0 : r_rx_cnt + 1'b1;
                if (r_rx_cnt == C_S0) r_rx_v0 <= w_rxd;
                if (r_rx_cnt == C_S1) r_rx_v1 <= w_rxd;
            end
            case (r_rx_state)
                S_IDLE: if (w_tick && r_rx_armed && !w_rxd) begin
                    r_rx_cnt   <= '0;
                    r_rx_pen   <= parity_en_i;
                    r_rx_odd   <= parity_odd_i;
                    r_rx_perr  <= 1'b0;
                    r_rx_state <= S_START;
                end
                S_START: begin
                    if (w_rx_decide && w_rx_vote) r_rx_state <= S_IDLE;
                    else if (w_rx_bit_end) begin
                        r_rx_bit   <= '0;
                        r_rx_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_rx_decide) r_rx_shift <= {w_rx_vote, r_rx_shift[DATA_BITS-1:1]};
                    if (w_rx_bit_end) begin
                        if (r_rx_bit == B_LAST) r_rx_state <= r_rx_pen ? S_PARITY : S_STOP;
                        else                    r_rx_bit   <= r_rx_bit + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_rx_decide)  r_rx_perr  <= w_rx_vote ^ (^r_rx_shift) ^ r_rx_odd;
                    if (w_rx_bit_end) r_rx_state <= S_STOP;
                end
                S_STOP: if (w_rx_decide) begin
                    // Disarm on a framing error so a held-low break yields a single frame.
                    r_rx_state <= S_IDLE;
                    if (!w_rx_vote) r_rx_armed <= 1'b0;
                    if (!r_rx_valid || rx_ready_i) begin
                        r_rx_data   <= r_rx_shift;
                        r_rx_perr_o <= r_rx_perr;
                        r_rx_ferr_o <= !w_rx_vote;
                        r_rx_valid  <= 1'b1;
                    end else begin
                        r_rx_ovr <= 1'b1;
                    end
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

    assign rx_data_o       = r_rx_data;
    assign rx_valid_o      = r_rx_valid;
    assign rx_parity_err_o = r_rx_perr_o;
    assign rx_frame_err_o  = r_rx_ferr_o;
    assign rx_overrun_o    = r_rx_ovr;

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed self-checking bench for uart_xcvr: TX timing, loopback sweep, RX error cases, reset.
module tb_uart_xcvr;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] baud_div = 16'd3;
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        two_stop = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        txd;
    logic        tb_rxd = 1'b1;
    logic        loop_en = 1'b0;
    logic        rxd_w;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        rx_perr;
    logic        rx_ferr;
    logic        rx_ovr;

    int tests = 0;
    int fails = 0;
    int ovr_cnt = 0;
    int vld_evt = 0;
    logic prev_v = 1'b0;

    localparam int BIT = 64;  // cycles per bit at baud_div=3

    assign rxd_w = loop_en ? txd : tb_rxd;

    always #5 clk = ~clk;

    uart_xcvr dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .baud_div_i      (baud_div),
        .parity_en_i     (parity_en),
        .parity_odd_i    (parity_odd),
        .two_stop_i      (two_stop),
        .tx_data_i       (tx_data),
        .tx_valid_i      (tx_valid),
        .tx_ready_o      (tx_ready),
        .uart_txd_o      (txd),
        .uart_rxd_i      (rxd_w),
        .rx_data_o       (rx_data),
        .rx_valid_o      (rx_valid),
        .rx_ready_i      (rx_ready),
        .rx_parity_err_o (rx_perr),
        .rx_frame_err_o  (rx_ferr),
        .rx_overrun_o    (rx_ovr)
    );

    always @(negedge clk) begin
        if (rx_ovr) ovr_cnt <= ovr_cnt + 1;
        if (rx_valid && !prev_v) vld_evt <= vld_evt + 1;
        prev_v <= rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_tx(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_rx_valid(input string tag, input int maxc);
        int n;
        n = 0;
        while (rx_valid !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(rx_valid), 32'd1);
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic pen, input logic pbit);
        @(negedge clk);
        tb_rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            tb_rxd = d[i];
            repeat (BIT) @(negedge clk);
        end
        if (pen) begin
            tb_rxd = pbit;
            repeat (BIT) @(negedge clk);
        end
        tb_rxd = 1'b1;
        repeat (BIT) @(negedge clk);
        $display("[TB] rx frame driven 0x%02h", d);
    endtask

    task automatic consume();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    logic s_txd [0:720];
    logic s_rdy [0:720];

    initial begin
        int L;
        int R;
        int bad;
        int e0;
        logic [7:0] a5;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_errs", 32'({rx_perr, rx_ferr, rx_ovr}), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("rel_tx_ready", 32'(tx_ready), 32'd1);
        repeat (4) @(negedge clk);

        // 1: TX waveform, 8N1, 0xA5, baud_div=3
        a5 = 8'hA5;
        send_tx(a5);
        $display("[TB] tx accepted 0xa5");
        for (int n = 1; n <= 720; n++) begin
            @(negedge clk);
            s_txd[n] = txd;
            s_rdy[n] = tx_ready;
        end
        L = 0;
        while (L < 700 && s_txd[L+1] === 1'b0) L++;
        chk("tx_start_len_64_67", 32'(L >= 64 && L <= 67), 32'd1);
        for (int i = 0; i < 8; i++) begin
            bad = 0;
            for (int j = 0; j < BIT; j++)
                if (s_txd[L + 1 + BIT*i + j] !== a5[i]) bad++;
            chk($sformatf("tx_bit%0d_bad_samples", i), 32'(bad), 32'd0);
        end
        bad = 0;
        for (int j = 0; j < BIT; j++)
            if (s_txd[L + 1 + 8*BIT + j] !== 1'b1) bad++;
        chk("tx_stop_bad_samples", 32'(bad), 32'd0);
        R = 0;
        while (R < 720 && s_rdy[R+1] === 1'b0) R++;
        chk("tx_ready_low_640_643", 32'(R >= 640 && R <= 643), 32'd1);
        chk("tx_ready_low_vs_start", 32'(R), 32'(L + 576));

        // 2: loopback 8E2 sweep at baud_div=0
        baud_div  = 16'd0;
        parity_en = 1'b1;
        parity_odd = 1'b0;
        two_stop  = 1'b1;
        loop_en   = 1'b1;
        rx_ready  = 1'b1;
        e0 = ovr_cnt;
        for (int v = 0; v < 256; v++) begin
            send_tx(8'(v));
            wait_rx_valid("loop_valid", 600);
            chk("loop_data", 32'(rx_data), 32'(v));
            chk("loop_perr", 32'(rx_perr), 32'd0);
            chk("loop_ferr", 32'(rx_ferr), 32'd0);
            $display("[TB] loopback sent 0x%02h got 0x%02h", v[7:0], rx_data);
            @(negedge clk);
        end
        chk("loop_overruns", 32'(ovr_cnt - e0), 32'd0);
        repeat (100) @(negedge clk);
        loop_en  = 1'b0;
        rx_ready = 1'b0;
        two_stop = 1'b0;
        baud_div = 16'd3;
        repeat (50) @(negedge clk);

        // 3: 8O1, 0x03 with wrong parity bit 0
        parity_en  = 1'b1;
        parity_odd = 1'b1;
        drive_rx(8'h03, 1'b1, 1'b0);
        wait_rx_valid("par_valid", 200);
        chk("par_data", 32'(rx_data), 32'h03);
        chk("par_perr", 32'(rx_perr), 32'd1);
        chk("par_ferr", 32'(rx_ferr), 32'd0);
        consume();
        chk("par_consumed", 32'(rx_valid), 32'd0);

        // 4: 20-cycle glitch rejected, then 0x5A 8N1
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        e0 = vld_evt;
        tb_rxd = 1'b0;
        repeat (20) @(negedge clk);
        tb_rxd = 1'b1;
        repeat (800) @(negedge clk);
        chk("glitch_no_valid", 32'(rx_valid), 32'd0);
        chk("glitch_no_event", 32'(vld_evt - e0), 32'd0);
        drive_rx(8'h5A, 1'b0, 1'b0);
        wait_rx_valid("glitch_next_valid", 200);
        chk("glitch_next_data", 32'(rx_data), 32'h5A);
        chk("glitch_next_errs", 32'({rx_perr, rx_ferr}), 32'd0);
        consume();

        // 5: overrun with rx_ready held low
        e0 = ovr_cnt;
        drive_rx(8'h11, 1'b0, 1'b0);
        drive_rx(8'h22, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        chk("ovr_pulses", 32'(ovr_cnt - e0), 32'd1);
        chk("ovr_held_valid", 32'(rx_valid), 32'd1);
        chk("ovr_held_data", 32'(rx_data), 32'h11);
        consume();
        chk("ovr_consumed", 32'(rx_valid), 32'd0);
        repeat (300) @(negedge clk);
        chk("ovr_no_second", 32'(rx_valid), 32'd0);

        // 6: break, 20 bit times low
        e0 = vld_evt;
        R = ovr_cnt;
        @(negedge clk);
        tb_rxd = 1'b0;
        repeat (20*BIT) @(negedge clk);
        chk("brk_valid", 32'(rx_valid), 32'd1);
        chk("brk_data", 32'(rx_data), 32'h00);
        chk("brk_ferr", 32'(rx_ferr), 32'd1);
        chk("brk_perr", 32'(rx_perr), 32'd0);
        chk("brk_no_overrun", 32'(ovr_cnt - R), 32'd0);
        consume();
        $display("[TB] break frame consumed");
        tb_rxd = 1'b1;
        repeat (300) @(negedge clk);
        chk("brk_one_frame", 32'(vld_evt - e0), 32'd1);
        chk("brk_idle_after", 32'(rx_valid), 32'd0);
        drive_rx(8'hC3, 1'b0, 1'b0);
        wait_rx_valid("brk_next_valid", 200);
        chk("brk_next_data", 32'(rx_data), 32'hC3);
        chk("brk_next_errs", 32'({rx_perr, rx_ferr}), 32'd0);
        consume();

        // Reset asserted mid-DATA on TX
        send_tx(8'h00);
        $display("[TB] tx accepted 0x00 before reset");
        repeat (200) @(negedge clk);
        chk("mid_txd_low", 32'(txd), 32'd0);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_txd", 32'(txd), 32'd1);
        chk("mid_rst_ready", 32'(tx_ready), 32'd0);
        chk("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", 32'(tx_ready), 32'd1);
        chk("mid_rel_txd", 32'(txd), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
